// File: rtl/norm_arbiter_pkg.sv
// Shared constants and the response record for the normaliser arbiter.
package norm_pkg;
  localparam int NREQ_DEF = 4;
  localparam int ID_W     = $clog2(NREQ_DEF);
  localparam int MANT_W   = 25;
  localparam int NUM_W    = 8;
  localparam int RES_W    = 24;
  localparam logic [NUM_W-1:0] NUM_RSHIFT = 8'hFF;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [NUM_W-1:0] num;
    logic [RES_W-1:0] res;
  } norm_rsp_t;
endpackage

// File: rtl/norm_arbiter_if.sv
// Requester, normaliser and response signals of the shared normaliser arbiter.
interface norm_arbiter_if
  import norm_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*MANT_W-1:0] req_v;
  logic [NREQ-1:0]        req_ready;
  logic [MANT_W-1:0]      norm_v;
  logic [NUM_W-1:0]       norm_num;
  logic [RES_W-1:0]       norm_res;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [NUM_W-1:0]       rsp_num;
  logic [RES_W-1:0]       rsp_res;

  modport master (
    output req_valid, req_v, norm_num, norm_res, rsp_ready,
    input  req_ready, norm_v, rsp_valid, rsp_id, rsp_num, rsp_res
  );

  modport slave (
    input  req_valid, req_v, norm_num, norm_res, rsp_ready,
    output req_ready, norm_v, rsp_valid, rsp_id, rsp_num, rsp_res
  );
endinterface

// File: rtl/norm_arbiter_rr_arb.sv
// Combinational round-robin arbiter: first requester after ptr wins, with wrap-around.
module rr_arb #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  logic          found_s;
  logic [PW-1:0] idx_s;

  // Scan N positions starting just after the last winner.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int i = 1; i <= N; i++) begin
      idx_s = PW'((int'(ptr) + i) % N);
      if (en && !found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end
endmodule

// File: rtl/norm_arbiter.sv
// Shares one single-cycle normaliser among NREQ units; results return in accept order
// through a 2-entry FIFO whose credit keeps the free-running normaliser output from being lost.
module norm_arbiter
  import norm_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic          clk,
  input logic          rst,
  norm_arbiter_if.slave bus
);
  logic [IDW-1:0]    ptr_r;
  logic              inflight_valid_r;
  logic [IDW-1:0]    inflight_id_r;
  norm_rsp_t         fifo_r [2];
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        count_r;

  logic [NREQ-1:0]   grant_s;
  logic [IDW-1:0]    gnt_id_s;
  logic [MANT_W-1:0] norm_v_s;
  logic              credit_s;
  logic              en_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  norm_rsp_t         head_s;

  // A pop in this cycle frees the slot the new accept will need two edges later.
  assign pop_s    = (count_r != 2'd0) && bus.rsp_ready;
  assign credit_s = (({1'b0, inflight_valid_r} + count_r) < 2'd2) || pop_s;
  assign en_s     = credit_s && !rst;
  assign accept_s = |grant_s;
  assign push_s   = inflight_valid_r;

  rr_arb #(.N(NREQ), .PW(IDW)) u_rr_arb (
    .req   (bus.req_valid),
    .en    (en_s),
    .ptr   (ptr_r),
    .grant (grant_s)
  );

  // Encode the one-hot grant and steer the winner's operand to the normaliser.
  always_comb begin
    gnt_id_s = '0;
    norm_v_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s[i]) begin
        gnt_id_s = IDW'(i);
        norm_v_s = bus.req_v[i*MANT_W +: MANT_W];
      end else begin
        norm_v_s = norm_v_s;
      end
    end
  end

  assign bus.req_ready = grant_s;
  assign bus.norm_v    = norm_v_s;

  // Round-robin pointer and the slot currently inside the normaliser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r            <= IDW'(NREQ - 1);
      inflight_valid_r <= 1'b0;
      inflight_id_r    <= '0;
    end else begin
      inflight_valid_r <= accept_s;
      if (accept_s) begin
        ptr_r         <= gnt_id_s;
        inflight_id_r <= gnt_id_s;
      end
    end
  end

  // Response FIFO: capture the normaliser output one edge after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_r[0] <= '0;
      fifo_r[1] <= '0;
      wr_ptr_r  <= 1'b0;
      rd_ptr_r  <= 1'b0;
      count_r   <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= {ID_W'(inflight_id_r), bus.norm_num, bus.norm_res};
        wr_ptr_r         <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_s        = fifo_r[rd_ptr_r];
  assign bus.rsp_valid = (count_r != 2'd0);
  assign bus.rsp_id    = IDW'(head_s.id);
  assign bus.rsp_num   = head_s.num;
  assign bus.rsp_res   = head_s.res;
endmodule

// File: tb/tb_norm_arbiter.sv
// Directed bench for norm_arbiter: vector table, hand sequences and an accept-order scoreboard.
module tb_norm_arbiter;
  import norm_pkg::*;

  typedef struct {
    logic [1:0]  id;
    logic [24:0] v;
    logic [3:0]  rdy;
    logic [7:0]  num;
    logic [23:0] res;
  } vec_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [7:0]  num;
    logic [23:0] res;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t sb_q[$];
  vec_t vecs[8];

  norm_arbiter_if #(.NREQ(4)) bus ();

  norm_arbiter #(.NREQ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] lz_model(input logic [24:0] v);
    logic [7:0]  n;
    logic [23:0] r;
    logic        found;
    n = 8'd0;
    r = 24'd0;
    found = 1'b0;
    if (v[24]) begin
      n = NUM_RSHIFT;
      r = v[24:1];
    end else begin
      for (int i = 23; i >= 0; i--) begin
        if (!found && v[i]) begin
          found = 1'b1;
          n = 8'(23 - i);
          r = v[23:0] << (23 - i);
        end
      end
    end
    return {n, r};
  endfunction

  // Behavioural stand-in for the one-cycle normaliser.
  always @(posedge clk) begin
    {bus.norm_num, bus.norm_res} <= lz_model(bus.norm_v);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: record accepts, check every popped response in accept order.
  always @(negedge clk) begin
    logic [24:0] op;
    logic [1:0]  gid;
    exp_t        e;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got id=%0d num=%0h res=%0h, none expected",
                   bus.rsp_id, bus.rsp_num, bus.rsp_res);
        end else begin
          e = sb_q.pop_front();
          chk("sb_rsp", {30'd0, bus.rsp_id, bus.rsp_num, bus.rsp_res}, {30'd0, e});
        end
      end
      if (|(bus.req_ready & bus.req_valid)) begin
        gid = 2'd0;
        for (int j = 0; j < 4; j++) begin
          if (bus.req_ready[j]) gid = 2'(j);
        end
        op = bus.req_v[gid*25 +: 25];
        sb_q.push_back({gid, lz_model(op)});
      end
    end
  end

  initial begin
    logic [3:0]  acc;
    logic [31:0] r;
    total = 0;
    bad   = 0;

    vecs[0] = '{2'd0, 25'h0400000, 4'b0001, 8'd1,  24'h800000};
    vecs[1] = '{2'd2, 25'h1000001, 4'b0100, 8'hFF, 24'h800000};
    vecs[2] = '{2'd2, 25'h0000000, 4'b0100, 8'd0,  24'h000000};
    vecs[3] = '{2'd1, 25'h0800000, 4'b0010, 8'd0,  24'h800000};
    vecs[4] = '{2'd1, 25'h0012345, 4'b0010, 8'd7,  24'h91A280};
    vecs[5] = '{2'd0, 25'h1FFFFFF, 4'b0001, 8'hFF, 24'hFFFFFF};
    vecs[6] = '{2'd3, 25'h0FFFFFF, 4'b1000, 8'd0,  24'hFFFFFF};
    vecs[7] = '{2'd3, 25'h0000001, 4'b1000, 8'd23, 24'h800000};

    // Reset state, with requests already pending.
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_v     = {4{25'h0000001}};
    bus.rsp_ready = 1'b1;
    #12;
    chk("rst_req_ready", {60'd0, bus.req_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    bus.req_valid = 4'b0000;
    @(posedge clk);
    #1 rst = 1'b0;

    // Single-request vectors: grant in cycle 0, response in cycle 2.
    for (int k = 0; k < 8; k++) begin
      bus.req_v = '0;
      bus.req_v[vecs[k].id*25 +: 25] = vecs[k].v;
      bus.req_valid = 4'b0001 << vecs[k].id;
      #1 chk("vec_ready", {60'd0, bus.req_ready}, {60'd0, vecs[k].rdy});
      tick();
      bus.req_valid = 4'b0000;
      #1 chk("vec_lat1", {63'd0, bus.rsp_valid}, 64'd0);
      tick();
      #1;
      chk("vec_valid", {63'd0, bus.rsp_valid}, 64'd1);
      chk("vec_id", {62'd0, bus.rsp_id}, {62'd0, vecs[k].id});
      chk("vec_num", {56'd0, bus.rsp_num}, {56'd0, vecs[k].num});
      chk("vec_res", {40'd0, bus.rsp_res}, {40'd0, vecs[k].res});
      tick();
      #1 chk("vec_empty", {63'd0, bus.rsp_valid}, 64'd0);
    end

    // All four valid: one grant per cycle, rotating from requester 0.
    bus.req_v = {4{25'h0000001}};
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1 chk("rr_ready", {60'd0, bus.req_ready}, {60'd0, 4'b0001 << (k % 4)});
      if (k >= 2) begin
        chk("rr_rsp_id", {62'd0, bus.rsp_id}, 64'((k - 2) % 4));
        chk("rr_rsp_num", {56'd0, bus.rsp_num}, 64'd23);
      end
      tick();
    end
    bus.req_valid = 4'b0000;
    repeat (3) tick();

    // Backpressure: two accepts, then stall until the consumer pops.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    #1 chk("bp_ready0", {60'd0, bus.req_ready}, 64'b0001);
    tick();
    #1 chk("bp_ready1", {60'd0, bus.req_ready}, 64'b0010);
    tick();
    #1 chk("bp_stall", {60'd0, bus.req_ready}, 64'd0);
    chk("bp_head", {62'd0, bus.rsp_id}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk("bp_hold_ready", {60'd0, bus.req_ready}, 64'd0);
      chk("bp_hold_valid", {63'd0, bus.rsp_valid}, 64'd1);
      chk("bp_hold_id", {62'd0, bus.rsp_id}, 64'd0);
    end
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_resume", {60'd0, bus.req_ready}, {60'd0, 4'b0100 << k | 4'b0100 >> (4 - k)});
      chk("bp_drain_id", {62'd0, bus.rsp_id}, 64'(k));
      tick();
    end
    bus.req_valid = 4'b0000;
    repeat (3) tick();

    // Asynchronous reset with a full FIFO.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    repeat (3) tick();
    chk("rstm_full", {63'd0, bus.rsp_valid}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstm_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rstm_ready", {60'd0, bus.req_ready}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.rsp_ready = 1'b1;
    #1 chk("rstm_first", {60'd0, bus.req_ready}, 64'b0001);
    tick();
    bus.req_valid = 4'b0000;
    tick();
    #1;
    chk("rstm_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
    chk("rstm_rsp_id", {62'd0, bus.rsp_id}, 64'd0);
    tick();
    #1 chk("rstm_no_stale", {63'd0, bus.rsp_valid}, 64'd0);
    repeat (3) tick();

    // Mixed traffic with random backpressure; the scoreboard checks every response.
    for (int k = 0; k < 80; k++) begin
      r = $urandom;
      bus.rsp_ready = r[0] | r[1];
      #1 acc = bus.req_ready & bus.req_valid;
      tick();
      for (int j = 0; j < 4; j++) begin
        if (!bus.req_valid[j] || acc[j]) begin
          r = $urandom;
          bus.req_valid[j] = r[31];
          bus.req_v[j*25 +: 25] = r[30] ? 25'h0000000 : r[24:0];
        end
      end
    end
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b1;
    repeat (5) tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/norm_arbiter.md
Name: norm_arbiter

Overview:
- Shares one leading-zero normaliser (lzsv: 25-bit in; 8-bit shift count and 24-bit normalised mantissa out; one registered cycle, no reset, no enable) among NREQ floating-point units, e.g. the adder and multiplier post-normalisation stages.
- Round-robin arbitration with a valid/ready handshake per requester.
- Tracks the in-flight slot and buffers results in a 2-entry response FIFO, so the free-running normaliser output is never lost under backpressure.
- Returns each result tagged with the requester id.

Parameters:
NREQ, 4, number of requesters (>=2)
IDW, $clog2(NREQ), width of requester id
MANT_W, 25, normaliser input width
NUM_W, 8, normaliser shift-count width
RES_W, 24, normalised mantissa width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester valid
req_v  in  NREQ*MANT_W  per-requester operand; requester i occupies bits [i*MANT_W +: MANT_W]
req_ready  out  NREQ  one-hot grant / accept
norm_v  out  MANT_W  operand driven to normaliser
norm_num  in  NUM_W  normaliser shift count, valid one cycle after norm_v
norm_res  in  RES_W  normaliser mantissa, valid one cycle after norm_v
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  IDW  requester that issued the operand
rsp_num  out  NUM_W  shift count, passed through unchanged (FF = right-shift 1; 0 for v=0)
rsp_res  out  RES_W  normalised mantissa, passed through unchanged

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - rr pointer = NREQ-1, so requester 0 has priority first.
  - inflight_valid = 0, FIFO empty, rsp_valid = 0, req_ready = 0.
  - Outstanding work is discarded. The normaliser's stale output is ignored because inflight_valid = 0.
- Credit rule: accept allowed when (inflight_valid + fifo_count) < 2, or when rsp_valid && rsp_ready in the same cycle.
- Grant (combinational):
  - If accept is allowed, grant the first i with req_valid[i], searching from ptr+1 with wrap-around.
  - req_ready = one-hot grant; all zero if no credit or no valid. req_ready may depend on req_valid.
  - Requesters must hold valid and operand stable until accepted.
- norm_v = req_v of the granted requester; all zeros when there is no grant.
- On accept at edge t:
  - ptr <= granted id.
  - inflight_valid <= 1, inflight_id <= granted id.
  - Otherwise inflight_valid <= 0.
- Capture at edge t+1: if inflight_valid, push {inflight_id, norm_num, norm_res} into the FIFO.
- Response:
  - rsp_* = FIFO head; rsp_valid = FIFO non-empty.
  - Pop on rsp_valid && rsp_ready.
  - Simultaneous push and pop with count = 2 is legal; the credit rule guarantees push never overflows.
- Latency: accept to rsp_valid = 2 cycles.
- Throughput: 1 accept per cycle while rsp_ready = 1.
- Ordering: responses are returned in accept order.
- rsp_* hold stable while rsp_valid && !rsp_ready.
- With rsp_ready = 0: at most 2 accepts, then req_ready = 0 until a pop.

Decomposition:
- Package norm_pkg:
  - MANT_W, NUM_W, RES_W constants.
  - NUM_RSHIFT = 8'hFF.
  - typedef struct norm_rsp_t {id, num, res} used as the FIFO entry.
- Sub-module rr_arb:
  - Parameter N.
  - Inputs: req, en, ptr.
  - Output: one-hot grant, combinational.
- FIFO is inline: 2 entries, rd/wr pointers, count.

Test Plan:
1. Single request: req0 v=25'h0400000, rsp_ready=1 -> req_ready=4'b0001 in cycle 0; rsp_valid in cycle 2 with id=0, num=1, res=24'h800000.
2. Overflow input: req2 v=25'h1000001 -> rsp id=2, num=8'hFF, res=24'h800000. Then v=0 -> num=0, res=0.
3. All four valid continuously, each v=25'h0000001, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; responses num=23, res=24'h800000, ids in the same order.
4. Backpressure: four requesters valid, rsp_ready=0 -> exactly two accepts (ids 0,1), then req_ready=0. Raise rsp_ready -> ids 0,1 drain in order, then accepts resume with id 2, one per cycle.
5. Reset mid-flight: FIFO holds 2 entries, assert rst asynchronously -> rsp_valid=0 in the same cycle. After release, the first grant goes to requester 0, and no stale response appears.
6. Simultaneous push/pop at count=2 with rsp_ready=1 and a new request -> accepted in that cycle; no response lost or duplicated, verified by a scoreboard.
